// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA2 descriptor engine: FSM encoding,
// descriptor attribute layout and fixed walk constants.
package adma_pkg;

    typedef enum logic [7:0] {
        ST_IDLE   = 8'b0000_0001,
        ST_FETCH  = 8'b0000_0010,
        ST_DECODE = 8'b0000_0100,
        ST_TRAN   = 8'b0000_1000,
        ST_LINK   = 8'b0001_0000,
        ST_NEXT   = 8'b0010_0000,
        ST_STOP   = 8'b0100_0000,
        ST_ERROR  = 8'b1000_0000
    } adma_state_e;

    localparam logic [1:0] ACT_NOP  = 2'b00;
    localparam logic [1:0] ACT_RSVD = 2'b01;
    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    localparam int ATTR_VALID  = 0;
    localparam int ATTR_END    = 1;
    localparam int ATTR_INT    = 2;
    localparam int ATTR_ACT_LO = 4;
    localparam int ATTR_ACT_HI = 5;

    localparam int DESC_STRIDE    = 12;
    localparam int LEN_ZERO_BYTES = 65536;

endpackage

// File: rtl/adma_desc_decode.sv
// Combinational field split of a latched descriptor plus the structural
// validity check (invalid entry or reserved action).
module adma_desc_decode
    import adma_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DESC_W = 96
) (
    input  logic [DESC_W-1:0] desc,
    output logic [ADDR_W-1:0] addr,
    output logic [16:0]       length,
    output logic              valid_bit,
    output logic              end_bit,
    output logic              int_bit,
    output logic [1:0]        act,
    output logic              bad
);

    logic [15:0] len_raw;
    logic        unused_bits;

    always_comb begin
        addr      = desc[DESC_W-1 -: ADDR_W];
        len_raw   = desc[31:16];
        // A zero length field encodes the full 64 KiB transfer.
        length    = (len_raw == 16'd0) ? 17'(LEN_ZERO_BYTES) : {1'b0, len_raw};
        valid_bit = desc[ATTR_VALID];
        end_bit   = desc[ATTR_END];
        int_bit   = desc[ATTR_INT];
        act       = desc[ATTR_ACT_HI:ATTR_ACT_LO];
        bad       = !valid_bit || (act == ACT_RSVD);
    end

    assign unused_bits = ^{desc[15:6], desc[3]};

endmodule

// File: rtl/adma_desc_engine.sv
// ADMA2 descriptor engine: walks a descriptor table, dispatching transfers,
// links and stops, and reports done/interrupt/error status to the host.
module adma_desc_engine
    import adma_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DESC_W   = 96,
    parameter int MAX_DESC = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              adma_start,
    input  logic [ADDR_W-1:0] desc_base_addr,
    output logic              fetch_start,
    output logic [ADDR_W-1:0] fetch_address,
    input  logic [DESC_W-1:0] address_descriptor,
    input  logic              address_fetch_done,
    output logic              tran_start,
    output logic [ADDR_W-1:0] tran_address,
    output logic [16:0]       tran_length,
    input  logic              tran_done,
    output logic              adma_busy,
    output logic              adma_done,
    output logic              adma_int,
    output logic              adma_error,
    output logic [ADDR_W-1:0] adma_err_addr
);

    localparam int CNT_W = $clog2(MAX_DESC + 1);

    adma_state_e       state;
    adma_state_e       state_next;
    logic              start_q;
    logic              first_fetch_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [DESC_W-1:0] desc_q;
    logic [CNT_W-1:0]  desc_count;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [ADDR_W-1:0] d_addr;
    logic [16:0]       d_len;
    logic              d_valid;
    logic              d_end;
    logic              d_int;
    logic [1:0]        d_act;
    logic              d_bad;

    logic start_edge;
    logic fetch_ok;
    logic count_hit;

    adma_desc_decode #(.ADDR_W(ADDR_W), .DESC_W(DESC_W)) u_decode (
        .desc      (desc_q),
        .addr      (d_addr),
        .length    (d_len),
        .valid_bit (d_valid),
        .end_bit   (d_end),
        .int_bit   (d_int),
        .act       (d_act),
        .bad       (d_bad)
    );

    assign start_edge = adma_start && !start_q;
    // The fetch stage holds done high while idle, so the first FETCH cycle's done is stale.
    assign fetch_ok   = (state == ST_FETCH) && !first_fetch_q && address_fetch_done;
    assign count_hit  = (desc_count == CNT_W'(MAX_DESC - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_edge) state_next = ST_FETCH;
            ST_FETCH:  if (fetch_ok) state_next = ST_DECODE;
            ST_DECODE: begin
                if (d_bad || count_hit) begin
                    state_next = ST_ERROR;
                end else begin
                    case (d_act)
                        ACT_TRAN: state_next = ST_TRAN;
                        ACT_LINK: state_next = ST_LINK;
                        default:  state_next = ST_NEXT;
                    endcase
                end
            end
            ST_TRAN:   if (tran_done) state_next = ST_NEXT;
            // A terminating link retires through NEXT so end/int handling is shared.
            ST_LINK:   state_next = d_end ? ST_NEXT : ST_FETCH;
            ST_NEXT:   state_next = d_end ? ST_STOP : ST_FETCH;
            ST_STOP:   state_next = ST_IDLE;
            ST_ERROR:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (state != ST_IDLE && !adma_start) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            start_q       <= 1'b0;
            first_fetch_q <= 1'b1;
            cur_addr      <= '0;
            desc_q        <= '0;
            desc_count    <= '0;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            start_q       <= adma_start;
            first_fetch_q <= (state != ST_FETCH);
            if (state == ST_IDLE && start_edge) begin
                cur_addr   <= desc_base_addr;
                desc_count <= '0;
                err_q      <= 1'b0;
                err_addr_q <= '0;
            end
            if (fetch_ok) begin
                desc_q <= address_descriptor;
            end
            if (state == ST_DECODE) begin
                desc_count <= desc_count + CNT_W'(1);
            end
            if (state == ST_DECODE && state_next == ST_ERROR) begin
                err_q      <= 1'b1;
                err_addr_q <= cur_addr;
            end
            if (state == ST_LINK && !d_end) begin
                cur_addr <= d_addr;
            end
            if (state == ST_NEXT && !d_end) begin
                cur_addr <= cur_addr + ADDR_W'(DESC_STRIDE);
            end
        end
    end

    always_comb begin
        fetch_start   = (state == ST_FETCH);
        fetch_address = fetch_start ? cur_addr : '0;
        tran_start    = (state == ST_TRAN);
        tran_address  = tran_start ? d_addr : '0;
        tran_length   = tran_start ? d_len : '0;
        adma_busy     = (state != ST_IDLE);
        adma_done     = (state == ST_STOP);
        adma_int      = (state == ST_NEXT) && d_int;
        adma_error    = err_q;
        adma_err_addr = err_addr_q;
    end

endmodule
